// File: rtl/uart_pkg.sv
// Shared constants for the buffered UART transmitter port.
// Register offsets, STATUS layout, serializer states, divisor floor.
package uart_pkg;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_BAUDDIV = 2'd2;
  localparam logic [1:0] OFF_RSVD    = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 8;

  localparam logic [15:0] MIN_DIV = 16'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [15:0] clamp_div(
    input logic [15:0] v
  );
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_port_fifo.sv
// Parameterised synchronous FIFO with occupancy count.
// Head is read combinationally; a push is seen only after its edge.
module sync_fifo_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered_port.sv
// Memory-mapped UART transmitter: register decode, divisor,
// overflow flag and the start/data/stop serializer.
module uart_tx_buffered_port
  import uart_pkg::*;
#(
  parameter int          DATA_LENGTH = 32,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_LENGTH-1:0] Address,
  input  logic [DATA_LENGTH-1:0] DataIn,
  output logic [DATA_LENGTH-1:0] DataOut,
  input  logic                   Select,
  input  logic                   Write,
  output logic                   tx,
  output logic [7:0]             tx_data,
  output logic                   busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    off;
  logic          wr_en;
  logic          push;
  logic          pop;
  logic          f_full;
  logic          f_empty;
  logic [7:0]    f_dout;
  logic [CW-1:0] f_count;
  logic          unused_bits;

  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  txd_q, txd_d;
  logic [15:0] fdiv_q, fdiv_d;
  logic        tx_q, tx_d;
  logic        last;
  logic        load;

  logic [DATA_LENGTH-1:0] status;
  logic [DATA_LENGTH-1:0] rdata;

  assign off   = Address[3:2];
  assign wr_en = Select & Write;
  assign push  = wr_en & (off == OFF_TXDATA);

  assign unused_bits = ^{Address[DATA_LENGTH-1:4],
                         Address[1:0],
                         DataIn[DATA_LENGTH-1:16]};

  sync_fifo_param #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (DataIn[7:0]),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_en && off == OFF_BAUDDIV)
      div_d = clamp_div(DataIn[15:0]);
    if (wr_en && off == OFF_STATUS && DataIn[ST_OVF])
      ovf_d = 1'b0;
    // A dropped byte outranks a clear on the same edge.
    if (push && f_full && !pop)
      ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    fdiv_d  = fdiv_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    load    = 1'b0;
    last    = (cnt_q == fdiv_q - 16'd1);
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        load = ~f_empty;
      end
      S_START: begin
        if (last) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          load    = ~f_empty;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Frame start: divisor is frozen here for the whole frame.
    if (load) begin
      pop     = 1'b1;
      shift_d = f_dout;
      txd_d   = f_dout;
      fdiv_d  = div_q;
      cnt_d   = '0;
      tx_d    = 1'b0;
      state_d = S_START;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= DEFAULT_DIV;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= '0;
      fdiv_q  <= DEFAULT_DIV;
      tx_q    <= 1'b1;
    end else begin
      div_q   <= div_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      fdiv_q  <= fdiv_d;
      tx_q    <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_data = txd_q;
  assign busy    = (state_q != S_IDLE);

  always_comb begin
    status               = '0;
    status[ST_FULL]      = f_full;
    status[ST_EMPTY]     = f_empty;
    status[ST_BUSY]      = busy;
    status[ST_OVF]       = ovf_q;
    status[ST_CNT +: CW] = f_count;
  end

  always_comb begin
    rdata = '0;
    if (Select) begin
      unique case (1'b1)
        (off == OFF_STATUS):  rdata = status;
        (off == OFF_BAUDDIV): rdata[15:0] = div_q;
        default: rdata = '0;
      endcase
    end
  end

  assign DataOut = rdata;

endmodule

// File: tb/tb_uart_tx_buffered_port.sv
// Directed bench for uart_tx_buffered_port.
// Bus accesses are driven and sampled on the falling edge.
module tb_uart_tx_buffered_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] DataIn = '0;
  logic [31:0] DataOut;
  logic        Select = 1'b0;
  logic        Write = 1'b0;
  logic        tx;
  logic [7:0]  tx_data;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  uart_tx_buffered_port #(
    .DATA_LENGTH (32),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd434)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .Address (Address),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .Select  (Select),
    .Write   (Write),
    .tx      (tx),
    .tx_data (tx_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(
    input logic [31:0] a,
    input logic [31:0] d
  );
    Address = a;
    DataIn  = d;
    Select  = 1'b1;
    Write   = 1'b1;
    @(negedge clk);
    Select  = 1'b0;
    Write   = 1'b0;
  endtask

  task automatic bus_read(
    input  logic [31:0] a,
    output logic [31:0] d
  );
    Address = a;
    Write   = 1'b0;
    Select  = 1'b1;
    #1;
    d = DataOut;
    Select  = 1'b0;
  endtask

  task automatic frame_chk(
    input string      tag,
    input logic [7:0] b,
    input int         div,
    input int         first,
    input int         last
  );
    int errs;
    int bcnt;
    int idx;
    logic e;
    errs = 0;
    bcnt = 0;
    for (int k = first; k < last; k++) begin
      idx = k / div;
      if (idx == 0)      e = 1'b0;
      else if (idx == 9) e = 1'b1;
      else               e = b[idx-1];
      if (tx !== e) errs++;
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
    end
    expect_eq({tag, "_tx_bits"}, errs, 0);
    expect_eq({tag, "_busy_cycles"}, bcnt, last - first);
  endtask

  logic [31:0] rd;
  logic [7:0]  seen;
  int          pops;
  int          saw_ee;
  int          done;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    expect_eq("rst_tx", tx, 1);
    expect_eq("rst_busy", busy, 0);
    bus_read(32'h4, rd);
    expect_eq("rst_status", rd, 32'h2);

    // reset in the middle of a frame
    bus_write(32'h0, 32'h77);
    repeat (50) @(negedge clk);
    expect_eq("pre_rst_txdata", tx_data, 8'h77);
    expect_eq("pre_rst_tx", tx, 0);
    rst = 1'b0;
    #1;
    expect_eq("midrst_tx", tx, 1);
    expect_eq("midrst_busy", busy, 0);
    expect_eq("midrst_txdata", tx_data, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_read(32'h4, rd);
    expect_eq("midrst_status", rd, 32'h2);
    bus_read(32'h8, rd);
    expect_eq("midrst_div", rd, 434);

    // decode
    Address = 32'h0;
    DataIn  = 32'h99;
    Write   = 1'b1;
    Select  = 1'b0;
    @(negedge clk);
    Write   = 1'b0;
    @(negedge clk);
    bus_read(32'h4, rd);
    expect_eq("nosel_nopush", rd, 32'h2);
    expect_eq("nosel_busy", busy, 0);
    bus_write(32'hC, 32'hFFFF_FFFF);
    bus_read(32'hC, rd);
    expect_eq("rsvd_read", rd, 0);
    bus_read(32'h8, rd);
    expect_eq("rsvd_no_effect", rd, 434);
    bus_read(32'h0, rd);
    expect_eq("txdata_read", rd, 0);
    Address = 32'h8;
    Select  = 1'b0;
    #1;
    expect_eq("nosel_dataout", DataOut, 0);
    @(negedge clk);

    // single byte
    bus_write(32'h8, 32'd4);
    bus_write(32'h0, 32'h55);
    expect_eq("lat_tx_hi", tx, 1);
    @(negedge clk);
    frame_chk("b55", 8'h55, 4, 0, 40);
    expect_eq("b55_idle_busy", busy, 0);
    expect_eq("b55_idle_tx", tx, 1);
    expect_eq("b55_txdata", tx_data, 8'h55);

    // back-to-back
    bus_write(32'h8, 32'd2);
    bus_write(32'h0, 32'hA5);
    bus_write(32'h0, 32'h3C);
    frame_chk("bA5", 8'hA5, 2, 0, 20);
    frame_chk("b3C", 8'h3C, 2, 0, 20);
    expect_eq("b2b_busy", busy, 0);
    bus_read(32'h4, rd);
    expect_eq("b2b_status", rd, 32'h2);
    expect_eq("b2b_txdata", tx_data, 8'h3C);

    // overflow
    bus_write(32'h8, 32'd100);
    for (int i = 0; i < 9; i++) bus_write(32'h0, 32'h10 + i);
    bus_read(32'h4, rd);
    expect_eq("ovf_full8", rd, 32'h805);
    bus_write(32'h0, 32'hEE);
    bus_read(32'h4, rd);
    expect_eq("ovf_set", rd, 32'h80D);
    bus_write(32'h4, 32'h8);
    bus_read(32'h4, rd);
    expect_eq("ovf_clear", rd, 32'h805);
    bus_write(32'h8, 32'd1);
    bus_read(32'h8, rd);
    expect_eq("div_clamp", rd, 2);

    seen   = tx_data;
    pops   = 0;
    saw_ee = 0;
    done   = 0;
    expect_eq("ovf_first", seen, 8'h10);
    for (int c = 0; c < 3000 && done == 0; c++) begin
      @(negedge clk);
      if (tx_data !== seen) begin
        pops++;
        if (tx_data == 8'hEE) saw_ee = 1;
        seen = tx_data;
      end
      if (busy === 1'b0) done = 1;
    end
    expect_eq("drain_done", done, 1);
    expect_eq("drain_pops", pops, 8);
    expect_eq("drain_last", seen, 8'h18);
    expect_eq("drain_no_ee", saw_ee, 0);
    bus_read(32'h4, rd);
    expect_eq("drain_status", rd, 32'h2);

    // mid-frame divisor change
    bus_write(32'h8, 32'd4);
    bus_write(32'h0, 32'h0F);
    bus_write(32'h0, 32'hF0);
    frame_chk("b0Fa", 8'h0F, 4, 0, 20);
    bus_write(32'h8, 32'd8);
    frame_chk("b0Fb", 8'h0F, 4, 21, 40);
    frame_chk("bF0", 8'hF0, 8, 0, 80);
    expect_eq("div8_idle", busy, 0);
    expect_eq("div8_txdata", tx_data, 8'hF0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
